i2c_xlate_table_ctrl: RTL

//  Programmable address-translation table and lookup sequencer for i2c_addr_translator.
//  The translator issues one lookup per decoded upstream address byte. This block scans
//  N_ENTRIES entries and returns the physical address and the downstream port (s1/s2).
//  A host configuration port writes or clears entries between lookups. Hit and miss

---
 rtl/i2c_xlate_table_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/i2c_xlate_table_ctrl.sv
// Address-translation table plus sequential lookup scanner for the I2C translator.
// Latency: hit at entry k acks k+2 cycles after lk_req, a full miss acks N_ENTRIES+1 after.
// Backpressure: lk_req and cfg_wr_en are dropped while busy; cfg_clr_all acts in any state.
module i2c_xlate_table_ctrl #(
  parameter int IDX_W        = 2,
  parameter int ADDR_W       = 7,
  parameter bit DEFAULT_PORT = 1'b0,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_wr_en,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic              cfg_valid,
  input  logic [ADDR_W-1:0] cfg_vaddr,
  input  logic [ADDR_W-1:0] cfg_paddr,
  input  logic              cfg_port,
  input  logic              cfg_clr_all,
  output logic              cfg_ready,
  input  logic              lk_req,
  input  logic [ADDR_W-1:0] lk_vaddr,
  output logic              busy,
  output logic              lk_ack,
  output logic              lk_hit,
  output logic [ADDR_W-1:0] lk_paddr,
  output logic              lk_port,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int N_ENTRIES = 2**IDX_W;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] vaddr;
    logic [ADDR_W-1:0] paddr;
    logic              port;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state, state_nxt;
  entry_t            tbl [N_ENTRIES];
  entry_t            cur_ent;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [ADDR_W-1:0] key;
  logic              cur_match;
  logic              last_idx;
  logic              res_load;
  logic              res_hit;
  logic              wr_accept;
  logic              req_accept;

  assign cfg_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign lk_ack     = (state == ST_RESP);
  assign req_accept = lk_req && (state == ST_IDLE);
  // Clear-all wins over a same-cycle write so the written entry stays invalid.
  assign wr_accept  = cfg_wr_en && (state == ST_IDLE) && !cfg_clr_all;

  assign cur_ent   = tbl[idx];
  assign cur_match = cur_ent.valid && (cur_ent.vaddr == key);
  assign last_idx  = &idx;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    res_load  = 1'b0;
    res_hit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (lk_req) begin
          state_nxt = ST_SCAN;
          idx_nxt   = '0;
        end
      end
      ST_SCAN: begin
        // Ascending scan that stops on the first match gives lowest-index priority.
        if (cur_match) begin
          state_nxt = ST_RESP;
          res_load  = 1'b1;
          res_hit   = 1'b1;
        end else if (last_idx) begin
          state_nxt = ST_RESP;
          res_load  = 1'b1;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      idx   <= '0;
      key   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (req_accept) key <= lk_vaddr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_ENTRIES; i++) tbl[i] <= '0;
    end else if (cfg_clr_all) begin
      for (int i = 0; i < N_ENTRIES; i++) tbl[i].valid <= 1'b0;
    end else if (wr_accept) begin
      tbl[cfg_idx] <= '{valid: cfg_valid, vaddr: cfg_vaddr, paddr: cfg_paddr, port: cfg_port};
    end
  end

  // Results and counters load on entry to RESP so they are stable while lk_ack is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      lk_hit   <= 1'b0;
      lk_paddr <= '0;
      lk_port  <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (res_load) begin
      lk_hit <= res_hit;
      if (res_hit) begin
        lk_paddr <= cur_ent.paddr;
        lk_port  <= cur_ent.port;
        if (!(&hit_cnt)) hit_cnt <= hit_cnt + CNT_W'(1);
      end else begin
        lk_paddr <= key;
        lk_port  <= DEFAULT_PORT;
        if (!(&miss_cnt)) miss_cnt <= miss_cnt + CNT_W'(1);
      end
    end
  end

endmodule
